btn_conditioner: RTL
====================

# btn_conditioner

Input conditioning stage between the board push-buttons and the washing-machine preset/entry logic. It synchronizes each raw button to `clk` and debounces it. For every button it produces a clean level, a one-cycle press pulse and a one-cycle release pulse. When enabled per button, it also produces auto-repeat press pulses while the button is held. Downstream digit-entry logic then increments on `btn_press` pulses instead of running its own hold-time counters.

## Interface
- `N_BTN`, 5: number of buttons. Bit order is fixed by the top level: {next, sign, p3, p2, p1}.
- `DEBOUNCE_CYC`, 2_000_000: consecutive stable cycles required to accept a level change (20 ms at 100 MHz). Must be ≥ 1.
- `REPEAT_DELAY`, 50_000_000: cycles from the press pulse to the first repeat pulse. Must be ≥ 2.
- `REPEAT_PERIOD`, 20_000_000: cycles between successive repeat pulses. Must be ≥ 2.
- `clk`  in  1  system clock. All state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  N_BTN  raw button inputs, active high, asynchronous to `clk`.
- `repeat_en`  in  N_BTN  per-button auto-repeat enable. Synchronous to `clk`.
- `btn_level`  out  N_BTN  debounced button level.
- `btn_press`  out  N_BTN  one-cycle pulse on each accepted press and on each repeat.
- `btn_release`  out  N_BTN  one-cycle pulse on each accepted release.
- `any_press`  out  1  OR-reduction of `btn_press`, registered in the same cycle as `btn_press`.

## Operation
- **Reset values.** While `rst_n` is low, every output, synchronizer flop, counter and FSM is forced to 0 / IDLE. Reset takes effect immediately, not at the next clock edge.
- **Synchronizer.** Each bit passes through a two-flop chain `s1 → s2`. All later logic sees only `s2`.
- **Debounce counter.** One counter per bit, width `$clog2(DEBOUNCE_CYC)` (minimum 1).
  - If `s2 == btn_level`: the counter clears to 0.
  - Else if the counter equals `DEBOUNCE_CYC-1`: `btn_level <= s2` and the counter clears.
  - Else: the counter increments.
  - A glitch shorter than `DEBOUNCE_CYC` cycles never reaches `btn_level`.
- **Edge pulses.** `btn_press` and `btn_release` are registered outputs.
  - `btn_press[i]` is high in exactly the cycle in which `btn_level[i]` first reads 1.
  - `btn_release[i]` is high in exactly the cycle in which `btn_level[i]` first reads 0.
- **Repeat FSM.** One FSM per bit, states IDLE, HOLD, REPEAT. Each FSM has a repeat counter sized for `max(REPEAT_DELAY, REPEAT_PERIOD)`.
  - IDLE → HOLD on the accepted rise. The counter clears.
  - HOLD, `repeat_en[i]` = 1: the counter increments. When it reaches `REPEAT_DELAY-1`, a press pulse is issued, the counter clears, and the FSM moves to REPEAT.
  - REPEAT: the counter increments. When it reaches `REPEAT_PERIOD-1`, a press pulse is issued and the counter clears.
  - HOLD or REPEAT with `repeat_en[i]` = 0: the FSM goes to (or stays in) HOLD with the counter held at 0. No repeat pulses are issued. Re-enabling restarts the full `REPEAT_DELAY`.
  - Any state → IDLE on the accepted fall. The counter clears.
- **Simultaneous events.**
  - If a release is accepted on the same edge a repeat would fire, the release wins: `btn_release` pulses and `btn_press` stays low.
  - All bits are independent. Any combination of bits may pulse in the same cycle.

## Timing
- Raw change present before edge 0 → `s2` changes at edge 1 → `btn_level` and the edge pulse update at edge `DEBOUNCE_CYC+1`.
- Let the press pulse occur at edge P. Repeat pulses then occur at edges P+REPEAT_DELAY+k·REPEAT_PERIOD, for k ≥ 0.
- Every pulse is exactly one clock wide. A pulse can never be stretched by another pulse.
- `any_press` has the same latency as `btn_press`.

## Test plan
All scenarios use `DEBOUNCE_CYC`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5.
- **Reset mid-hold.** Reset low for 3 cycles while `btn_raw`=5'h1F → all outputs are 0 during reset. After release, `btn_level`=5'h1F at edge 5 and `btn_press`=5'h1F for one cycle. Asserting `rst_n` low again mid-hold clears all outputs immediately, with no release pulse.
- **Clean press and release.** Raise `btn_raw[0]` before edge 0 and hold it for 30 cycles, with `repeat_en`=0 → `btn_level[0]` rises at edge 5, with a single `btn_press[0]` at edge 5 and no further pulses. Drop `btn_raw[0]` → `btn_release[0]` pulses 5 edges later.
- **Glitch rejection.** Pulse `btn_raw[1]` high for 3 cycles, then low → `btn_level[1]` stays 0 and there are no pulses. A 4-cycle-stable pulse, by contrast, is accepted.
- **Auto-repeat.** Hold `btn_raw[2]` with `repeat_en[2]`=1; press at edge 5 → repeats at edges 15, 20, 25, 30. Release accepted at edge 35 → `btn_release` only, no press pulse at edge 35.
- **Repeat disable mid-hold.** As in the auto-repeat scenario, but drop `repeat_en[2]` at edge 17 and restore it at edge 22 → no pulse at edge 20. The next repeat is at edge 32, i.e. 10 cycles after the restore.
- **Independent buttons.** Press `btn_raw[0]` and `btn_raw[3]` two cycles apart → each gets its own press pulse, with the same latency, 2 cycles apart. `any_press` shows both pulses.

Source files
------------

// File: rtl/btn_conditioner.sv
// Push-button conditioning: two-flop synchronizer, debounce, press/release pulses
// and optional per-button auto-repeat press pulses while a button is held.
module btn_conditioner #(
    parameter int unsigned N_BTN         = 5,
    parameter int unsigned DEBOUNCE_CYC  = 2_000_000,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_PERIOD = 20_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_press
);

    localparam int unsigned DEB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRepeat
    } rep_state_e;

    logic [N_BTN-1:0] s1_q;
    logic [N_BTN-1:0] s2_q;
    logic [N_BTN-1:0] level_d;
    logic [N_BTN-1:0] press_d;
    logic [N_BTN-1:0] release_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            s2_q        <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            any_press   <= 1'b0;
        end else begin
            s1_q        <= btn_raw;
            s2_q        <= s1_q;
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
            any_press   <= |press_d;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [DEB_W-1:0] deb_cnt_q;
        logic [DEB_W-1:0] deb_cnt_d;
        logic [REP_W-1:0] rep_cnt_q;
        logic [REP_W-1:0] rep_cnt_d;
        rep_state_e       state_q;
        rep_state_e       state_d;
        logic             rise;
        logic             fall;
        logic             fire;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_cnt_q <= '0;
                rep_cnt_q <= '0;
                state_q   <= StIdle;
            end else begin
                deb_cnt_q <= deb_cnt_d;
                rep_cnt_q <= rep_cnt_d;
                state_q   <= state_d;
            end
        end

        // Any sample matching the current level restarts the stability count.
        always_comb begin
            deb_cnt_d = deb_cnt_q;
            rise      = 1'b0;
            fall      = 1'b0;
            if (s2_q[i] == btn_level[i]) begin
                deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                deb_cnt_d = '0;
                rise      = s2_q[i];
                fall      = ~s2_q[i];
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end

        always_comb begin
            state_d   = state_q;
            rep_cnt_d = rep_cnt_q;
            fire      = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_d   = StHold;
                        rep_cnt_d = '0;
                    end
                end
                StHold: begin
                    if (!repeat_en[i]) begin
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q == DELAY_LAST) begin
                        fire      = 1'b1;
                        rep_cnt_d = '0;
                        state_d   = StRepeat;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
                StRepeat: begin
                    if (!repeat_en[i]) begin
                        state_d   = StHold;
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q == PERIOD_LAST) begin
                        fire      = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1);
                    end
                end
                default: begin
                    state_d   = StIdle;
                    rep_cnt_d = '0;
                end
            endcase
            // A release accepted on the same edge suppresses a pending repeat.
            if (fall) begin
                state_d   = StIdle;
                rep_cnt_d = '0;
                fire      = 1'b0;
            end
        end

        assign level_d[i]   = btn_level[i] ^ (rise | fall);
        assign press_d[i]   = rise | fire;
        assign release_d[i] = fall;
    end

endmodule
